// File: rtl/psum_accumulator_if.sv
// Handshake and configuration bundle between the MAC controller, the partial-sum
// accumulator and the ofmap writer.
interface psum_accumulator_if #(
    parameter int PSUM_WIDTH = 16,
    parameter int CH_WIDTH   = 10,
    parameter int PIX_WIDTH  = 16
);
    logic                  start;
    logic [CH_WIDTH-1:0]   num_channels;
    logic [PIX_WIDTH-1:0]  num_pixels;
    logic [PSUM_WIDTH-1:0] threshold;
    logic                  out_mode;
    logic [4:0]            mac_in;
    logic                  mac_valid;
    logic                  mac_ready;
    logic [PSUM_WIDTH-1:0] acc_out;
    logic                  bin_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    modport master (
        output start, num_channels, num_pixels, threshold, out_mode,
        output mac_in, mac_valid, out_ready,
        input  mac_ready, acc_out, bin_out, out_valid, busy, done, overflow
    );

    modport slave (
        input  start, num_channels, num_pixels, threshold, out_mode,
        input  mac_in, mac_valid, out_ready,
        output mac_ready, acc_out, bin_out, out_valid, busy, done, overflow
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates per-window MAC results over N channels into one saturated psum per
// output pixel and hands raw or binarised results out through a one-deep register.
module psum_accumulator #(
    parameter int PSUM_WIDTH = 16,
    parameter int CH_WIDTH   = 10,
    parameter int PIX_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    psum_accumulator_if.slave  bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

    localparam logic [CH_WIDTH-1:0]   CH_ONE   = CH_WIDTH'(1'b1);
    localparam logic [PIX_WIDTH-1:0]  PIX_ONE  = PIX_WIDTH'(1'b1);
    localparam logic [PSUM_WIDTH-1:0] PSUM_MAX = {PSUM_WIDTH{1'b1}};

    // MSB of the result is the carry flag; the low bits are already clamped.
    function automatic logic [PSUM_WIDTH:0] sat_add(input logic [PSUM_WIDTH-1:0] a,
                                                     input logic [4:0] b);
        logic [PSUM_WIDTH:0] sum;
        sum = {1'b0, a} + {{(PSUM_WIDTH-4){1'b0}}, b};
        if (sum[PSUM_WIDTH]) begin
            sat_add = {1'b1, PSUM_MAX};
        end else begin
            sat_add = sum;
        end
    endfunction

    state_t                state_r, state_s;
    logic [CH_WIDTH-1:0]   n_r, ch_cnt_r;
    logic [PIX_WIDTH-1:0]  p_r, pix_cnt_r;
    logic [PSUM_WIDTH-1:0] thr_r, acc_r, acc_out_r;
    logic                  mode_r, bin_out_r, out_valid_r, out_last_r, overflow_r;

    logic [PSUM_WIDTH:0]   add_s;
    logic [PSUM_WIDTH-1:0] sum_s;
    logic                  carry_s, bin_s, start_ok_s, mac_ready_s, beat_s;
    logic                  last_ch_s, last_pix_s, load_s, hs_s;

    assign add_s       = sat_add(acc_r, bus.mac_in);
    assign carry_s     = add_s[PSUM_WIDTH];
    assign sum_s       = add_s[PSUM_WIDTH-1:0];
    assign bin_s       = (sum_s >= thr_r);
    // A pending result blocks a new job so its data is never overwritten.
    assign start_ok_s  = (state_r == IDLE) && bus.start && !out_valid_r;
    assign mac_ready_s = (state_r == ACC) && (!out_valid_r || bus.out_ready);
    assign beat_s      = bus.mac_valid && mac_ready_s;
    assign last_ch_s   = (ch_cnt_r == (n_r - CH_ONE));
    assign last_pix_s  = (pix_cnt_r == (p_r - PIX_ONE));
    assign load_s      = beat_s && last_ch_s;
    assign hs_s        = out_valid_r && bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_s = ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (load_s && last_pix_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ACC;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Job configuration, captured on an accepted start; zero counts mean one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r    <= CH_ONE;
            p_r    <= PIX_ONE;
            thr_r  <= {PSUM_WIDTH{1'b0}};
            mode_r <= 1'b0;
        end else if (start_ok_s) begin
            n_r    <= (bus.num_channels == {CH_WIDTH{1'b0}}) ? CH_ONE : bus.num_channels;
            p_r    <= (bus.num_pixels == {PIX_WIDTH{1'b0}}) ? PIX_ONE : bus.num_pixels;
            thr_r  <= bus.threshold;
            mode_r <= bus.out_mode;
        end
    end

    // Running psum, channel/pixel counters and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= {PSUM_WIDTH{1'b0}};
            ch_cnt_r   <= {CH_WIDTH{1'b0}};
            pix_cnt_r  <= {PIX_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (start_ok_s) begin
            acc_r      <= {PSUM_WIDTH{1'b0}};
            ch_cnt_r   <= {CH_WIDTH{1'b0}};
            pix_cnt_r  <= {PIX_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (beat_s) begin
            if (carry_s) begin
                overflow_r <= 1'b1;
            end
            if (last_ch_s) begin
                acc_r     <= {PSUM_WIDTH{1'b0}};
                ch_cnt_r  <= {CH_WIDTH{1'b0}};
                pix_cnt_r <= pix_cnt_r + PIX_ONE;
            end else begin
                acc_r    <= sum_s;
                ch_cnt_r <= ch_cnt_r + CH_ONE;
            end
        end
    end

    // One-deep output register; a new load wins over a same-cycle drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out_r   <= {PSUM_WIDTH{1'b0}};
            bin_out_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (load_s) begin
            acc_out_r   <= mode_r ? sum_s : {{(PSUM_WIDTH-1){1'b0}}, bin_s};
            bin_out_r   <= bin_s;
            out_valid_r <= 1'b1;
            out_last_r  <= last_pix_s;
        end else if (hs_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.mac_ready = mac_ready_s;
    assign bus.acc_out   = acc_out_r;
    assign bus.bin_out   = bin_out_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = (state_r == ACC) || out_valid_r;
    assign bus.done      = hs_s && out_last_r;
    assign bus.overflow  = overflow_r;
endmodule
